// File: rtl/cpu_control_fsm.sv
// cpu_control_fsm: multi-cycle control unit for a 16-bit accumulator-free CPU.
// Walks FETCH -> DECODE -> EXEC -> [MEM] -> [WB] and drives datapath strobes.
// Optional interrupt entry is compiled in when the macro CTRL_IRQ_EN is defined.
module cpu_control_fsm #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter logic [15:0] IRQ_VECTOR  = 16'h0004
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] instr_i,
    input  logic        zero_flag_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    input  logic        mem_ack_i,
    output logic        addr_sel_o,
    output logic        ir_load_o,
    output logic        pc_inc_o,
    output logic        pc_load_o,
    output logic        pc_src_o,
    output logic [2:0]  alu_op_o,
    output logic        rf_we_o,
    output logic [1:0]  rf_src_o,
    input  logic        irq_i,
    output logic        irq_ack_o,
    output logic        halted_o,
    output logic        fault_o,
    output logic [3:0]  state_o
);

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StExec   = 4'd2,
        StMem    = 4'd3,
        StWb     = 4'd4,
        StHalt   = 4'd5,
        StFault  = 4'd6,
        StIrq    = 4'd7
    } state_e;

    localparam logic [3:0] OpNop  = 4'h0;
    localparam logic [3:0] OpAdd  = 4'h1;
    localparam logic [3:0] OpSub  = 4'h2;
    localparam logic [3:0] OpAnd  = 4'h3;
    localparam logic [3:0] OpOr   = 4'h4;
    localparam logic [3:0] OpLdi  = 4'h5;
    localparam logic [3:0] OpLd   = 4'h6;
    localparam logic [3:0] OpSt   = 4'h7;
    localparam logic [3:0] OpBz   = 4'h8;
    localparam logic [3:0] OpJmp  = 4'h9;
    localparam logic [3:0] OpHalt = 4'hF;

    localparam int unsigned    WaitW   = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WaitW-1:0] WaitMax = WaitW'(MEM_TIMEOUT);

    state_e           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [WaitW-1:0] wait_q, wait_d;
    logic             mem_ack_seen;
    logic [2:0]       alu_code;

    logic             mem_req_q, mem_req_d;
    logic             mem_we_q, mem_we_d;
    logic             addr_sel_q, addr_sel_d;
    logic [2:0]       alu_op_q, alu_op_d;
    logic             pc_load_q, pc_load_d;
    logic             pc_src_q, pc_src_d;
    logic             rf_we_q, rf_we_d;
    logic [1:0]       rf_src_q, rf_src_d;
    logic             halted_q, halted_d;
    logic             fault_q, fault_d;
`ifdef CTRL_IRQ_EN
    logic             irq_armed_q, irq_armed_d;
    logic             irq_ack_q, irq_ack_d;
`endif

    // Next-state, opcode latch and memory wait counter.
    always_comb begin
        mem_ack_seen = mem_req_q & mem_ack_i;  // ack without a request is ignored
        state_d      = state_q;
        op_d         = op_q;
        case (state_q)
            StFetch: begin
                if (mem_ack_seen)           state_d = StDecode;
                else if (wait_q == WaitMax) state_d = StFault;
            end
            StDecode: begin
                op_d = instr_i[15:12];
                if (op_d == OpNop)       state_d = StFetch;
                else if (op_d == OpHalt) state_d = StHalt;
                else if (op_d > OpJmp)   state_d = StFault;
                else                     state_d = StExec;
            end
            StExec: begin
                if (op_q == OpLd || op_q == OpSt)       state_d = StMem;
                else if (op_q == OpBz || op_q == OpJmp) state_d = StFetch;
                else                                    state_d = StWb;
            end
            StMem: begin
                if (mem_ack_seen)           state_d = (op_q == OpLd) ? StWb : StFetch;
                else if (wait_q == WaitMax) state_d = StFault;
            end
            StWb, StIrq:     state_d = StFetch;
            StHalt, StFault: state_d = state_q;
            default:         state_d = StFault;
        endcase
`ifdef CTRL_IRQ_EN
        // Interrupts are taken only on entry to FETCH, and once per low-to-high of irq.
        if (state_d == StFetch && state_q != StFetch && irq_i && irq_armed_q) begin
            state_d = StIrq;
        end
        irq_armed_d = irq_armed_q;
        if (state_d == StIrq) irq_armed_d = 1'b0;
        else if (!irq_i)      irq_armed_d = 1'b1;
`endif
        wait_d = wait_q;
        if (state_d != state_q || mem_ack_seen) wait_d = '0;
        else if (mem_req_q)                     wait_d = wait_q + 1'b1;
    end

    // Moore outputs for the state being entered, registered alongside the state.
    always_comb begin
        case (op_d)
            OpAdd:       alu_code = 3'd0;
            OpSub:       alu_code = 3'd1;
            OpAnd:       alu_code = 3'd2;
            OpOr:        alu_code = 3'd3;
            OpLd, OpSt:  alu_code = 3'd4;
            default:     alu_code = 3'd0;
        endcase
        // Request drops once the wait budget is spent; FAULT follows next edge.
        mem_req_d  = (state_d == StFetch || state_d == StMem) && (wait_d != WaitMax);
        mem_we_d   = (state_d == StMem) && (op_d == OpSt);
        addr_sel_d = (state_d == StMem);
        // ALU code held through MEM/WB so address and result stay valid.
        alu_op_d   = (state_d == StExec || state_d == StMem || state_d == StWb) ? alu_code : 3'd0;
        pc_load_d  = (state_d == StExec && (op_d == OpJmp || (op_d == OpBz && zero_flag_i)))
                     || (state_d == StIrq);
        pc_src_d   = (state_d == StIrq);
        rf_we_d    = (state_d == StWb);
        rf_src_d   = 2'd0;
        if (state_d == StWb) begin
            if (op_d == OpLd)       rf_src_d = 2'd1;
            else if (op_d == OpLdi) rf_src_d = 2'd2;
        end
        halted_d   = (state_d == StHalt);
        fault_d    = (state_d == StFault);
`ifdef CTRL_IRQ_EN
        irq_ack_d  = (state_d == StIrq);
`endif
    end

    // State and registered outputs; reset clears everything asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StFetch;
            op_q       <= OpNop;
            wait_q     <= '0;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            addr_sel_q <= 1'b0;
            alu_op_q   <= 3'd0;
            pc_load_q  <= 1'b0;
            pc_src_q   <= 1'b0;
            rf_we_q    <= 1'b0;
            rf_src_q   <= 2'd0;
            halted_q   <= 1'b0;
            fault_q    <= 1'b0;
`ifdef CTRL_IRQ_EN
            irq_armed_q <= 1'b1;
            irq_ack_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            wait_q     <= wait_d;
            mem_req_q  <= mem_req_d;
            mem_we_q   <= mem_we_d;
            addr_sel_q <= addr_sel_d;
            alu_op_q   <= alu_op_d;
            pc_load_q  <= pc_load_d;
            pc_src_q   <= pc_src_d;
            rf_we_q    <= rf_we_d;
            rf_src_q   <= rf_src_d;
            halted_q   <= halted_d;
            fault_q    <= fault_d;
`ifdef CTRL_IRQ_EN
            irq_armed_q <= irq_armed_d;
            irq_ack_q   <= irq_ack_d;
`endif
        end
    end

    // Fetch strobes are qualified by the ack in the same cycle.
    assign ir_load_o  = (state_q == StFetch) & mem_ack_seen;
    assign pc_inc_o   = (state_q == StFetch) & mem_ack_seen;
    assign mem_req_o  = mem_req_q;
    assign mem_we_o   = mem_we_q;
    assign addr_sel_o = addr_sel_q;
    assign alu_op_o   = alu_op_q;
    assign pc_load_o  = pc_load_q;
    assign pc_src_o   = pc_src_q;
    assign rf_we_o    = rf_we_q;
    assign rf_src_o   = rf_src_q;
    assign halted_o   = halted_q;
    assign fault_o    = fault_q;
    assign state_o    = state_q;

`ifdef CTRL_IRQ_EN
    assign irq_ack_o = irq_ack_q;
`else
    assign irq_ack_o = 1'b0;
    logic unused_irq;
    assign unused_irq = irq_i;
`endif

    // Register fields and the vector itself are consumed by the datapath, not here.
    logic [27:0] unused_bits;
    assign unused_bits = {instr_i[11:0], IRQ_VECTOR};

endmodule
